// File: rtl/multicycle_control_unit.sv
// Multicycle control FSM for the RISC-V core: fetch with memory wait states, opcode decode,
// per-class execute/writeback sequences, branch resolution and a sticky illegal-instruction trap.
module multicycle_control_unit #(
  parameter int MEM_LATENCY = 1,
  parameter int ALU_OP_W    = 3
) (
  input  logic                CLK,
  input  logic                RST_N,
  input  logic [6:0]          OPCODE,
  input  logic [2:0]          FUNCT3,
  input  logic                FUNCT7_B5,
  input  logic                ZERO,
  output logic                reset_wire,
  output logic [ALU_OP_W-1:0] operacao,
  output logic                WRITE_PC,
  output logic                PC_SRC,
  output logic                LOAD_IR,
  output logic                WR_MEM_INSTR,
  output logic                RD_MEM_DATA,
  output logic                WR_MEM_DATA,
  output logic                REG_WRITE,
  output logic                MEM_TO_REG,
  output logic [1:0]          ALU_SRC_B,
  output logic                ILLEGAL,
  output logic [3:0]          STATE
);

  typedef enum logic [3:0] {
    S_RESET    = 4'd0,
    S_FETCH    = 4'd1,
    S_LOAD_IR  = 4'd2,
    S_PC_INC   = 4'd3,
    S_DECODE   = 4'd4,
    S_EXEC_R   = 4'd5,
    S_EXEC_I   = 4'd6,
    S_WB_ALU   = 4'd7,
    S_MEM_ADDR = 4'd8,
    S_MEM_RD   = 4'd9,
    S_WB_MEM   = 4'd10,
    S_MEM_WR   = 4'd11,
    S_BRANCH   = 4'd12,
    S_LUI      = 4'd13,
    S_TRAP     = 4'd14
  } state_t;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;

  localparam logic [ALU_OP_W-1:0] ALU_PASS_B = ALU_OP_W'(0);
  localparam logic [ALU_OP_W-1:0] ALU_ADD    = ALU_OP_W'(1);
  localparam logic [ALU_OP_W-1:0] ALU_SUB    = ALU_OP_W'(2);
  localparam logic [ALU_OP_W-1:0] ALU_AND    = ALU_OP_W'(3);
  localparam logic [ALU_OP_W-1:0] ALU_XOR    = ALU_OP_W'(4);
  localparam logic [ALU_OP_W-1:0] ALU_OR     = ALU_OP_W'(5);

  localparam logic [1:0] SRCB_RS2  = 2'b00;
  localparam logic [1:0] SRCB_IMM  = 2'b01;
  localparam logic [1:0] SRCB_FOUR = 2'b10;

  localparam int              CNT_W    = (MEM_LATENCY < 1) ? 1 : $clog2(MEM_LATENCY + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MEM_LATENCY);

  state_t             state_reg, state_next;
  logic [CNT_W-1:0]   cnt_reg, cnt_next;
  logic               cnt_done;
  logic               r_type;
  logic [ALU_OP_W-1:0] alu_op;
  logic               alu_legal;

  assign cnt_done     = (cnt_reg == CNT_LAST);
  assign r_type       = (OPCODE == OP_R);
  assign STATE        = state_reg;
  assign WR_MEM_INSTR = 1'b0;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_reg <= S_RESET;
      cnt_reg   <= '0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
    end
  end

  // FUNCT7_B5 only selects sub on R-type; I-type has no immediate subtract.
  always_comb begin
    alu_op    = ALU_PASS_B;
    alu_legal = 1'b1;
    case (FUNCT3)
      3'b000:  alu_op = (r_type && FUNCT7_B5) ? ALU_SUB : ALU_ADD;
      3'b111:  alu_op = ALU_AND;
      3'b100:  alu_op = ALU_XOR;
      3'b110:  alu_op = ALU_OR;
      default: alu_legal = 1'b0;
    endcase
  end

  always_comb begin
    state_next  = state_reg;
    reset_wire  = 1'b0;
    operacao    = ALU_PASS_B;
    WRITE_PC    = 1'b0;
    PC_SRC      = 1'b0;
    LOAD_IR     = 1'b0;
    RD_MEM_DATA = 1'b0;
    WR_MEM_DATA = 1'b0;
    REG_WRITE   = 1'b0;
    MEM_TO_REG  = 1'b0;
    ALU_SRC_B   = SRCB_RS2;
    ILLEGAL     = 1'b0;
    case (state_reg)
      S_RESET: begin
        reset_wire = 1'b1;
        state_next = S_FETCH;
      end
      S_FETCH: begin
        if (cnt_done) state_next = S_LOAD_IR;
      end
      S_LOAD_IR: begin
        LOAD_IR    = 1'b1;
        state_next = S_PC_INC;
      end
      S_PC_INC: begin
        operacao   = ALU_ADD;
        ALU_SRC_B  = SRCB_FOUR;
        WRITE_PC   = 1'b1;
        state_next = S_DECODE;
      end
      S_DECODE: begin
        case (OPCODE)
          OP_R:              state_next = S_EXEC_R;
          OP_I:              state_next = S_EXEC_I;
          OP_LOAD, OP_STORE: state_next = S_MEM_ADDR;
          OP_BRANCH:         state_next = S_BRANCH;
          OP_LUI:            state_next = S_LUI;
          default:           state_next = S_TRAP;
        endcase
      end
      S_EXEC_R: begin
        operacao   = alu_op;
        ALU_SRC_B  = SRCB_RS2;
        state_next = alu_legal ? S_WB_ALU : S_TRAP;
      end
      S_EXEC_I: begin
        operacao   = alu_op;
        ALU_SRC_B  = SRCB_IMM;
        state_next = alu_legal ? S_WB_ALU : S_TRAP;
      end
      // IR is still stable here, so the execute-state ALU setup is recomputed from it.
      S_WB_ALU: begin
        REG_WRITE  = 1'b1;
        operacao   = alu_op;
        ALU_SRC_B  = r_type ? SRCB_RS2 : SRCB_IMM;
        state_next = S_FETCH;
      end
      S_MEM_ADDR: begin
        operacao   = ALU_ADD;
        ALU_SRC_B  = SRCB_IMM;
        state_next = (OPCODE == OP_LOAD) ? S_MEM_RD : S_MEM_WR;
      end
      S_MEM_RD: begin
        RD_MEM_DATA = 1'b1;
        if (cnt_done) state_next = S_WB_MEM;
      end
      S_WB_MEM: begin
        REG_WRITE  = 1'b1;
        MEM_TO_REG = 1'b1;
        state_next = S_FETCH;
      end
      S_MEM_WR: begin
        WR_MEM_DATA = 1'b1;
        state_next  = S_FETCH;
      end
      S_BRANCH: begin
        operacao  = ALU_SUB;
        ALU_SRC_B = SRCB_RS2;
        PC_SRC    = 1'b1;
        case (FUNCT3)
          3'b000: begin
            WRITE_PC   = ZERO;
            state_next = S_FETCH;
          end
          3'b001: begin
            WRITE_PC   = !ZERO;
            state_next = S_FETCH;
          end
          default: state_next = S_TRAP;
        endcase
      end
      S_LUI: begin
        operacao   = ALU_PASS_B;
        ALU_SRC_B  = SRCB_IMM;
        REG_WRITE  = 1'b1;
        state_next = S_FETCH;
      end
      S_TRAP: begin
        ILLEGAL = 1'b1;
      end
      default: state_next = S_RESET;
    endcase
  end

  // Only the two wait states count; everything else clears, so TRAP can never wrap it.
  always_comb begin
    cnt_next = '0;
    if ((state_next == state_reg) && ((state_reg == S_FETCH) || (state_reg == S_MEM_RD)))
      cnt_next = cnt_reg + 1'b1;
  end

endmodule

// File: tb/tb_multicycle_control_unit.sv
// Directed bench for multicycle_control_unit: three instances with MEM_LATENCY 1, 2, 3
// share stimulus; each scenario checks the instance whose latency it needs.
module tb_multicycle_control_unit;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;

  logic       CLK;
  logic       RST_N;
  logic [6:0] OPCODE;
  logic [2:0] FUNCT3;
  logic       FUNCT7_B5;
  logic       ZERO;

  // index 0: MEM_LATENCY=1, 1: MEM_LATENCY=2, 2: MEM_LATENCY=3
  logic       reset_wire_w [3];
  logic [2:0] operacao_w   [3];
  logic       write_pc_w   [3];
  logic       pc_src_w     [3];
  logic       load_ir_w    [3];
  logic       wr_instr_w   [3];
  logic       rd_data_w    [3];
  logic       wr_data_w    [3];
  logic       reg_write_w  [3];
  logic       mem_to_reg_w [3];
  logic [1:0] alu_src_b_w  [3];
  logic       illegal_w    [3];
  logic [3:0] state_w      [3];

  int checks = 0;
  int errors = 0;

  generate
    for (genvar gi = 0; gi < 3; gi++) begin : g_dut
      multicycle_control_unit #(
        .MEM_LATENCY(gi + 1),
        .ALU_OP_W   (3)
      ) u_dut (
        .CLK         (CLK),
        .RST_N       (RST_N),
        .OPCODE      (OPCODE),
        .FUNCT3      (FUNCT3),
        .FUNCT7_B5   (FUNCT7_B5),
        .ZERO        (ZERO),
        .reset_wire  (reset_wire_w[gi]),
        .operacao    (operacao_w[gi]),
        .WRITE_PC    (write_pc_w[gi]),
        .PC_SRC      (pc_src_w[gi]),
        .LOAD_IR     (load_ir_w[gi]),
        .WR_MEM_INSTR(wr_instr_w[gi]),
        .RD_MEM_DATA (rd_data_w[gi]),
        .WR_MEM_DATA (wr_data_w[gi]),
        .REG_WRITE   (reg_write_w[gi]),
        .MEM_TO_REG  (mem_to_reg_w[gi]),
        .ALU_SRC_B   (alu_src_b_w[gi]),
        .ILLEGAL     (illegal_w[gi]),
        .STATE       (state_w[gi])
      );
    end
  endgenerate

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Sets the instruction fields, pulses reset, and returns at the negedge right after release
  // (state RESET visible, first FETCH cycle one negedge later).
  task automatic start(input logic [6:0] op, input logic [2:0] f3, input logic b5, input logic z);
    OPCODE = op; FUNCT3 = f3; FUNCT7_B5 = b5; ZERO = z;
    @(negedge CLK); RST_N = 1'b0;
    @(negedge CLK); RST_N = 1'b1;
  endtask

  task automatic test_reset();
    OPCODE = OP_R; FUNCT3 = 3'b000; FUNCT7_B5 = 1'b0; ZERO = 1'b0;
    @(negedge CLK); #2 RST_N = 1'b0; #1;
    checks++; if (state_w[1] !== 4'd0) begin errors++; $display("FAIL reset_async_state: got %0d expected 0", state_w[1]); end
    @(negedge CLK); RST_N = 1'b1;
    checks++; if (state_w[1] !== 4'd0) begin errors++; $display("FAIL reset_state: got %0d expected 0", state_w[1]); end
    checks++; if (reset_wire_w[1] !== 1'b1) begin errors++; $display("FAIL reset_wire: got %0b expected 1", reset_wire_w[1]); end
    checks++; if ({write_pc_w[1], load_ir_w[1], wr_instr_w[1], reg_write_w[1]} !== 4'b0) begin
      errors++; $display("FAIL reset_strobes: got %b expected 0000", {write_pc_w[1], load_ir_w[1], wr_instr_w[1], reg_write_w[1]});
    end
    for (int c = 1; c <= 3; c++) begin
      @(negedge CLK);
      checks++; if (state_w[1] !== 4'd1 || load_ir_w[1] !== 1'b0 || reset_wire_w[1] !== 1'b0) begin
        errors++; $display("FAIL fetch_cycle%0d: got state %0d load_ir %0b expected state 1 load_ir 0", c, state_w[1], load_ir_w[1]);
      end
    end
    @(negedge CLK);
    checks++; if (state_w[1] !== 4'd2 || load_ir_w[1] !== 1'b1 || write_pc_w[1] !== 1'b0) begin
      errors++; $display("FAIL load_ir_cycle4: got state %0d load_ir %0b write_pc %0b expected 2 1 0", state_w[1], load_ir_w[1], write_pc_w[1]);
    end
    @(negedge CLK);
    checks++; if (state_w[1] !== 4'd3 || write_pc_w[1] !== 1'b1 || load_ir_w[1] !== 1'b0) begin
      errors++; $display("FAIL pc_inc_cycle5: got state %0d write_pc %0b expected 3 1", state_w[1], write_pc_w[1]);
    end
    checks++; if (operacao_w[1] !== 3'b001 || alu_src_b_w[1] !== 2'b10 || pc_src_w[1] !== 1'b0) begin
      errors++; $display("FAIL pc_inc_alu: got op %b srcb %b pc_src %b expected 001 10 0", operacao_w[1], alu_src_b_w[1], pc_src_w[1]);
    end
  endtask

  task automatic test_r_type();
    int rw;
    rw = 0;
    start(OP_R, 3'b000, 1'b1, 1'b0);
    for (int c = 1; c <= 8; c++) begin
      @(negedge CLK);
      if (reg_write_w[0] === 1'b1) rw++;
      if (c == 6) begin
        checks++; if (state_w[0] !== 4'd5 || operacao_w[0] !== 3'b010) begin
          errors++; $display("FAIL r_exec: got state %0d op %b expected 5 010", state_w[0], operacao_w[0]);
        end
      end
      if (c == 7) begin
        checks++; if (state_w[0] !== 4'd7 || reg_write_w[0] !== 1'b1 || mem_to_reg_w[0] !== 1'b0) begin
          errors++; $display("FAIL r_wb: got state %0d reg_write %0b mem_to_reg %0b expected 7 1 0", state_w[0], reg_write_w[0], mem_to_reg_w[0]);
        end
      end
      if (c == 8) begin
        checks++; if (state_w[0] !== 4'd1) begin errors++; $display("FAIL r_refetch: got state %0d expected 1", state_w[0]); end
      end
    end
    checks++; if (rw != 1) begin errors++; $display("FAIL r_reg_write_cycles: got %0d expected 1", rw); end
  endtask

  task automatic test_alu_decode();
    // {opcode, funct3, funct7_b5, exp_op, exp_srcb, legal}
    logic [16:0] vec [9];
    logic [6:0] op; logic [2:0] f3; logic b5; logic [2:0] eop; logic [1:0] esb; logic legal;
    logic [3:0] exec_st;
    vec = '{{OP_R, 3'b000, 1'b1, 3'b010, 2'b00, 1'b1},
            {OP_R, 3'b000, 1'b0, 3'b001, 2'b00, 1'b1},
            {OP_R, 3'b111, 1'b0, 3'b011, 2'b00, 1'b1},
            {OP_R, 3'b100, 1'b1, 3'b100, 2'b00, 1'b1},
            {OP_R, 3'b110, 1'b0, 3'b101, 2'b00, 1'b1},
            {OP_I, 3'b000, 1'b1, 3'b001, 2'b01, 1'b1},
            {OP_I, 3'b111, 1'b1, 3'b011, 2'b01, 1'b1},
            {OP_R, 3'b001, 1'b0, 3'b000, 2'b00, 1'b0},
            {OP_I, 3'b101, 1'b0, 3'b000, 2'b01, 1'b0}};
    for (int i = 0; i < 9; i++) begin
      {op, f3, b5, eop, esb, legal} = vec[i];
      exec_st = (op == OP_R) ? 4'd5 : 4'd6;
      start(op, f3, b5, 1'b0);
      repeat (6) @(negedge CLK);
      checks++; if (state_w[0] !== exec_st || alu_src_b_w[0] !== esb || (legal && operacao_w[0] !== eop)) begin
        errors++; $display("FAIL alu_exec[%0d]: got state %0d op %b srcb %b expected %0d %b %b", i, state_w[0], operacao_w[0], alu_src_b_w[0], exec_st, eop, esb);
      end
      @(negedge CLK);
      if (legal) begin
        checks++; if (state_w[0] !== 4'd7 || reg_write_w[0] !== 1'b1 || operacao_w[0] !== eop || alu_src_b_w[0] !== esb) begin
          errors++; $display("FAIL alu_wb[%0d]: got state %0d rw %0b op %b srcb %b expected 7 1 %b %b", i, state_w[0], reg_write_w[0], operacao_w[0], alu_src_b_w[0], eop, esb);
        end
      end else begin
        checks++; if (state_w[0] !== 4'd14 || reg_write_w[0] !== 1'b0 || illegal_w[0] !== 1'b1) begin
          errors++; $display("FAIL alu_trap[%0d]: got state %0d rw %0b illegal %0b expected 14 0 1", i, state_w[0], reg_write_w[0], illegal_w[0]);
        end
      end
    end
  endtask

  task automatic test_load_store();
    int rd_cnt, wr_cnt, rw_ld, rw_st, clash;
    rd_cnt = 0; wr_cnt = 0; rw_ld = 0; rw_st = 0; clash = 0;
    start(OP_LOAD, 3'b010, 1'b0, 1'b0);
    for (int c = 1; c <= 23; c++) begin
      @(negedge CLK);
      if (rd_data_w[2] === 1'b1) rd_cnt++;
      if (wr_data_w[2] === 1'b1 && c > 14) wr_cnt++;
      if (reg_write_w[2] === 1'b1) begin if (c <= 14) rw_ld++; else rw_st++; end
      if ((wr_data_w[2] && reg_write_w[2]) || (load_ir_w[2] && write_pc_w[2])) clash++;
      case (c)
        8: begin
          checks++; if (state_w[2] !== 4'd8 || operacao_w[2] !== 3'b001 || alu_src_b_w[2] !== 2'b01) begin
            errors++; $display("FAIL ld_addr: got state %0d op %b srcb %b expected 8 001 01", state_w[2], operacao_w[2], alu_src_b_w[2]);
          end
        end
        9: begin
          checks++; if (state_w[2] !== 4'd9 || rd_data_w[2] !== 1'b1) begin
            errors++; $display("FAIL ld_rd_start: got state %0d rd %0b expected 9 1", state_w[2], rd_data_w[2]);
          end
        end
        13: begin
          checks++; if (state_w[2] !== 4'd10 || reg_write_w[2] !== 1'b1 || mem_to_reg_w[2] !== 1'b1 || rd_data_w[2] !== 1'b0) begin
            errors++; $display("FAIL ld_wb: got state %0d rw %0b m2r %0b rd %0b expected 10 1 1 0", state_w[2], reg_write_w[2], mem_to_reg_w[2], rd_data_w[2]);
          end
        end
        14: begin
          checks++; if (state_w[2] !== 4'd1) begin errors++; $display("FAIL ld_refetch: got state %0d expected 1", state_w[2]); end
          checks++; if (rd_cnt != 4) begin errors++; $display("FAIL ld_rd_cycles: got %0d expected 4", rd_cnt); end
          checks++; if (rw_ld != 1) begin errors++; $display("FAIL ld_rw_cycles: got %0d expected 1", rw_ld); end
          OPCODE = OP_STORE;
        end
        22: begin
          checks++; if (state_w[2] !== 4'd11 || wr_data_w[2] !== 1'b1 || reg_write_w[2] !== 1'b0) begin
            errors++; $display("FAIL st_wr: got state %0d wr %0b rw %0b expected 11 1 0", state_w[2], wr_data_w[2], reg_write_w[2]);
          end
        end
        23: begin
          checks++; if (state_w[2] !== 4'd1 || wr_data_w[2] !== 1'b0) begin
            errors++; $display("FAIL st_refetch: got state %0d wr %0b expected 1 0", state_w[2], wr_data_w[2]);
          end
        end
        default: ;
      endcase
    end
    checks++; if (wr_cnt != 1) begin errors++; $display("FAIL st_wr_cycles: got %0d expected 1", wr_cnt); end
    checks++; if (rw_st != 0) begin errors++; $display("FAIL st_rw_cycles: got %0d expected 0", rw_st); end
    checks++; if (clash != 0) begin errors++; $display("FAIL strobe_clash: got %0d expected 0", clash); end
  endtask

  task automatic test_branch();
    // {funct3, zero, exp_write_pc, exp_next_state}
    logic [8:0] vec [5];
    logic [2:0] f3; logic z; logic ewpc; logic [3:0] enext;
    vec = '{{3'b000, 1'b1, 1'b1, 4'd1},
            {3'b000, 1'b0, 1'b0, 4'd1},
            {3'b001, 1'b0, 1'b1, 4'd1},
            {3'b001, 1'b1, 1'b0, 4'd1},
            {3'b100, 1'b1, 1'b0, 4'd14}};
    for (int i = 0; i < 5; i++) begin
      {f3, z, ewpc, enext} = vec[i];
      start(OP_BRANCH, f3, 1'b0, z);
      repeat (6) @(negedge CLK);
      checks++; if (state_w[0] !== 4'd12 || write_pc_w[0] !== ewpc || pc_src_w[0] !== 1'b1 || operacao_w[0] !== 3'b010 || alu_src_b_w[0] !== 2'b00) begin
        errors++; $display("FAIL branch[%0d]: got state %0d wpc %0b pc_src %0b op %b expected 12 %0b 1 010", i, state_w[0], write_pc_w[0], pc_src_w[0], operacao_w[0], ewpc);
      end
      @(negedge CLK);
      checks++; if (state_w[0] !== enext) begin errors++; $display("FAIL branch_next[%0d]: got %0d expected %0d", i, state_w[0], enext); end
    end
  endtask

  task automatic test_lui();
    start(OP_LUI, 3'b000, 1'b0, 1'b0);
    repeat (6) @(negedge CLK);
    checks++; if (state_w[0] !== 4'd13 || reg_write_w[0] !== 1'b1 || operacao_w[0] !== 3'b000 || alu_src_b_w[0] !== 2'b01) begin
      errors++; $display("FAIL lui: got state %0d rw %0b op %b srcb %b expected 13 1 000 01", state_w[0], reg_write_w[0], operacao_w[0], alu_src_b_w[0]);
    end
    @(negedge CLK);
    checks++; if (state_w[0] !== 4'd1 || reg_write_w[0] !== 1'b0) begin
      errors++; $display("FAIL lui_next: got state %0d rw %0b expected 1 0", state_w[0], reg_write_w[0]);
    end
  endtask

  task automatic test_illegal();
    int bad;
    bad = 0;
    start(7'b1111111, 3'b000, 1'b0, 1'b0);
    repeat (6) @(negedge CLK);
    checks++; if (state_w[0] !== 4'd14 || illegal_w[0] !== 1'b1) begin
      errors++; $display("FAIL trap_entry: got state %0d illegal %0b expected 14 1", state_w[0], illegal_w[0]);
    end
    repeat (20) begin
      @(negedge CLK);
      if (illegal_w[0] !== 1'b1 || state_w[0] !== 4'd14 ||
          {reset_wire_w[0], write_pc_w[0], load_ir_w[0], rd_data_w[0], wr_data_w[0], reg_write_w[0]} !== 6'b0) bad++;
    end
    checks++; if (bad != 0) begin errors++; $display("FAIL trap_hold: got %0d bad cycles expected 0", bad); end
    #2 RST_N = 1'b0; #1;
    checks++; if (state_w[0] !== 4'd0 || illegal_w[0] !== 1'b0) begin
      errors++; $display("FAIL trap_reset: got state %0d illegal %0b expected 0 0", state_w[0], illegal_w[0]);
    end
    @(negedge CLK); RST_N = 1'b1;
    @(negedge CLK);
    checks++; if (state_w[0] !== 4'd1 || illegal_w[0] !== 1'b0) begin
      errors++; $display("FAIL trap_refetch: got state %0d illegal %0b expected 1 0", state_w[0], illegal_w[0]);
    end
  endtask

  task automatic test_async_reset();
    start(OP_LOAD, 3'b010, 1'b0, 1'b0);
    repeat (10) @(negedge CLK);
    checks++; if (state_w[2] !== 4'd9 || rd_data_w[2] !== 1'b1) begin
      errors++; $display("FAIL async_pre: got state %0d rd %0b expected 9 1", state_w[2], rd_data_w[2]);
    end
    #2 RST_N = 1'b0; #1;
    checks++; if (state_w[2] !== 4'd0 || rd_data_w[2] !== 1'b0 || reset_wire_w[2] !== 1'b1) begin
      errors++; $display("FAIL async_mid_load: got state %0d rd %0b rw %0b expected 0 0 1", state_w[2], rd_data_w[2], reset_wire_w[2]);
    end
    @(negedge CLK); RST_N = 1'b1;
    for (int c = 1; c <= 4; c++) begin
      @(negedge CLK);
      checks++; if (state_w[2] !== 4'd1) begin errors++; $display("FAIL async_fetch%0d: got state %0d expected 1", c, state_w[2]); end
    end
    @(negedge CLK);
    checks++; if (state_w[2] !== 4'd2 || load_ir_w[2] !== 1'b1) begin
      errors++; $display("FAIL async_load_ir: got state %0d load_ir %0b expected 2 1", state_w[2], load_ir_w[2]);
    end
  endtask

  initial begin
    RST_N = 1'b0; OPCODE = 7'b0; FUNCT3 = 3'b0; FUNCT7_B5 = 1'b0; ZERO = 1'b0;
    test_reset();
    test_r_type();
    test_alu_decode();
    test_load_store();
    test_branch();
    test_lui();
    test_illegal();
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/multicycle_control_unit.md
Name: multicycle_control_unit

Overview:
- Parametrised multicycle control FSM for the RISC-V core.
- Successor to the fixed fetch/increment/load-IR sequencer. Adds:
  - configurable memory wait states;
  - opcode decode and per-class execute/writeback sequences;
  - conditional branch resolution;
  - a sticky illegal-instruction trap.
- Sits between the instruction register/ALU flags and the datapath muxes, register file and memories.

Parameters:
- MEM_LATENCY, 1: extra wait cycles for an instruction or data memory read; legal range 0..15.
- ALU_OP_W, 3: width of the operacao bus.

Ports:
- CLK  in  1  system clock, rising edge.
- RST_N  in  1  asynchronous active-low reset.
- OPCODE  in  7  IR[6:0].
- FUNCT3  in  3  IR[14:12].
- FUNCT7_B5  in  1  IR[30].
- ZERO  in  1  ALU zero flag, valid in the BRANCH state.
- reset_wire  out  1  datapath register reset.
- operacao  out  ALU_OP_W  ALU operation: 000 pass B, 001 add, 010 sub, 011 and, 100 xor, 101 or.
- WRITE_PC  out  1  PC load enable.
- PC_SRC  out  1  0 = PC+4, 1 = branch target. The target is computed by the datapath from the old-PC register.
- LOAD_IR  out  1  instruction register load enable.
- WR_MEM_INSTR  out  1  instruction memory write; tied 0.
- RD_MEM_DATA  out  1  data memory read strobe.
- WR_MEM_DATA  out  1  data memory write strobe.
- REG_WRITE  out  1  register file write enable.
- MEM_TO_REG  out  1  writeback source: 1 = memory, 0 = ALU.
- ALU_SRC_B  out  2  ALU B source: 00 rs2, 01 immediate, 10 constant 4.
- ILLEGAL  out  1  trap flag.
- STATE  out  4  current state encoding, for debug.

Behaviour:
- Reset
  - Single clock; reset is asynchronous and active-low (RST_N).
  - RST_N low forces state RESET immediately, mid-instruction included; the wait counter clears to 0.
- Output defaults
  - Outputs are a combinational function of state, plus FUNCT3, FUNCT7_B5 and ZERO where stated.
  - Every output defaults to 0 unless listed for a state.
  - In RESET: reset_wire = 1, all others 0.
- States, outputs and transitions:
  - RESET(0): reset_wire = 1; -> FETCH.
  - FETCH(1): lasts MEM_LATENCY+1 cycles, counted by an internal counter; -> LOAD_IR when count == MEM_LATENCY. MEM_LATENCY = 0 gives exactly 1 cycle.
  - LOAD_IR(2): LOAD_IR = 1; -> PC_INC.
  - PC_INC(3): operacao = 001, ALU_SRC_B = 10, WRITE_PC = 1, PC_SRC = 0; -> DECODE.
  - DECODE(4): no strobes. Next state by OPCODE:
    - 0110011 -> EXEC_R
    - 0010011 -> EXEC_I
    - 0000011 or 0100011 -> MEM_ADDR
    - 1100011 -> BRANCH
    - 0110111 -> LUI
    - anything else -> TRAP
  - EXEC_R(5): operacao decoded from FUNCT3/FUNCT7_B5, ALU_SRC_B = 00; -> WB_ALU.
  - EXEC_I(6): operacao decoded with FUNCT7_B5 ignored, ALU_SRC_B = 01; -> WB_ALU.
  - WB_ALU(7): REG_WRITE = 1, MEM_TO_REG = 0; operacao and ALU_SRC_B held from the execute state; -> FETCH.
  - MEM_ADDR(8): operacao = 001, ALU_SRC_B = 01. -> MEM_RD if OPCODE = 0000011, otherwise -> MEM_WR.
  - MEM_RD(9): RD_MEM_DATA = 1 for MEM_LATENCY+1 cycles, using the same counter; -> WB_MEM.
  - WB_MEM(10): REG_WRITE = 1, MEM_TO_REG = 1; -> FETCH.
  - MEM_WR(11): WR_MEM_DATA = 1 for exactly 1 cycle; -> FETCH.
  - BRANCH(12): operacao = 010, ALU_SRC_B = 00, PC_SRC = 1. WRITE_PC = ZERO when FUNCT3 = 000 (beq), WRITE_PC = !ZERO when FUNCT3 = 001 (bne). Any other FUNCT3 -> TRAP, with no PC write. Otherwise -> FETCH.
  - LUI(13): operacao = 000, ALU_SRC_B = 01, REG_WRITE = 1; -> FETCH.
  - TRAP(14): ILLEGAL = 1, no strobes. Stays here until reset.
- ALU operation decode (FUNCT3 -> operacao):
  - 000 -> 001 (add); 010 (sub) instead if R-type and FUNCT7_B5 = 1.
  - 111 -> 011 (and).
  - 100 -> 100 (xor).
  - 110 -> 101 (or).
  - Any other FUNCT3 on R/I-type -> TRAP instead of WB_ALU; REG_WRITE is never asserted for it.
- Cycles per instruction, L = MEM_LATENCY:
  - R/I-type: L+6.
  - Load: 2L+7.
  - Store: L+6.
  - Branch, LUI: L+5.
- Strobe invariants:
  - WR_MEM_DATA and REG_WRITE are never both 1.
  - LOAD_IR and WRITE_PC are never both 1.
- Counter
  - Width is max(1, $clog2(MEM_LATENCY+1)).
  - Clears on every state entry; must not wrap within a state.

Test Plan:
- Reset/fetch, MEM_LATENCY = 2: release RST_N -> RESET 1 cycle (reset_wire = 1), FETCH 3 cycles, LOAD_IR = 1 on cycle 4, WRITE_PC = 1 with operacao = 001 and ALU_SRC_B = 10 on cycle 5.
- R-type, OPCODE = 0110011, FUNCT3 = 000, FUNCT7_B5 = 1, MEM_LATENCY = 1 -> EXEC_R with operacao = 010, REG_WRITE = 1 exactly one cycle, back in FETCH 7 cycles after the previous FETCH entry.
- Load then store, MEM_LATENCY = 3: load -> RD_MEM_DATA high for 4 cycles, then WB_MEM with MEM_TO_REG = 1 and REG_WRITE = 1, total 13 cycles. Store -> WR_MEM_DATA for 1 cycle, REG_WRITE never 1.
- Branch, beq with ZERO = 1 -> WRITE_PC = 1, PC_SRC = 1. beq with ZERO = 0 -> WRITE_PC = 0. bne with ZERO = 0 -> WRITE_PC = 1. FUNCT3 = 100 -> TRAP.
- Illegal: OPCODE = 1111111 -> ILLEGAL = 1 and held for 20 cycles with no strobes. RST_N pulse -> RESET, ILLEGAL = 0.
- Async reset mid-load: drop RST_N during MEM_RD, between clock edges -> STATE = 0 and RD_MEM_DATA = 0 before the next edge; clean fetch after release.
